prefix_sequencer: RTL

Controls the Super FX register-select datapath: the TO/FROM prefix latches and the source/destination select muxes. The block accepts one opcode at a time from the fetch stage and decodes the prefix opcodes TO, FROM, WITH and ALT1-3. It drives the to/from/resflags strobes and the ssel/dsel mux selects, tracks the B flag, and hands ordinary instructions to the execute unit. At instruction completion it clears all prefix state.

---
 rtl/sfx_seq_pkg.sv | 32 +++
 rtl/prefix_sequencer_if.sv | 24 ++
 rtl/prefix_opcode_classifier.sv | 32 +++
 rtl/prefix_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sfx_seq_pkg.sv
// Shared types and constants for the Super FX prefix sequencer:
// FSM states, register-select mux codes and opcode-class values.
package sfx_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_CLEAR  = 2'd3
  } seq_state_t;

  localparam logic [1:0] SEL_HA     = 2'b00;
  localparam logic [1:0] SEL_INSTR  = 2'b01;
  localparam logic [1:0] SEL_ZERO   = 2'b10;
  localparam logic [1:0] SEL_PREFIX = 2'b11;

  localparam logic [3:0] OP_TO_HI   = 4'h1;
  localparam logic [3:0] OP_WITH_HI = 4'h2;
  localparam logic [3:0] OP_FROM_HI = 4'hB;

  localparam logic [7:0] OP_ALT1 = 8'h3D;
  localparam logic [7:0] OP_ALT2 = 8'h3E;
  localparam logic [7:0] OP_ALT3 = 8'h3F;

  localparam logic [1:0] ALT_NONE = 2'b00;

  // The low two bits of 0x3D..0x3F are exactly the ALT mode they select.
  function automatic logic [1:0] alt_mode(input logic [7:0] op);
    return op[1:0];
  endfunction

endpackage

// File: rtl/prefix_sequencer_if.sv
// Fetch/execute handshake bundle between the opcode source and the sequencer.
interface prefix_sequencer_if;
  logic [7:0] opcode;
  logic       op_valid;
  logic       op_ready;
  logic       exec_done;
  logic       exec_start;

  modport master (
    output opcode,
    output op_valid,
    output exec_done,
    input  op_ready,
    input  exec_start
  );

  modport slave (
    input  opcode,
    input  op_valid,
    input  exec_done,
    output op_ready,
    output exec_start
  );
endinterface

// File: rtl/prefix_opcode_classifier.sv
// Combinational opcode-class decode for the prefix sequencer.
// ALT prefixes are recognised only when SEQ_ALT_PREFIX_EN is defined.
module prefix_opcode_classifier
  import sfx_seq_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_to,
  output logic       is_from,
  output logic       is_with,
  output logic       is_alt,
  output logic [1:0] alt_code
);

  always_comb begin
    is_to   = (opcode[7:4] == OP_TO_HI);
    is_from = (opcode[7:4] == OP_FROM_HI);
    is_with = (opcode[7:4] == OP_WITH_HI);
`ifdef SEQ_ALT_PREFIX_EN
    is_alt   = (opcode == OP_ALT1) || (opcode == OP_ALT2) || (opcode == OP_ALT3);
    alt_code = is_alt ? alt_mode(opcode) : ALT_NONE;
`else
    is_alt   = 1'b0;
    alt_code = ALT_NONE;
`endif
  end

`ifndef SEQ_ALT_PREFIX_EN
  logic unused_low;
  assign unused_low = ^opcode[3:0];
`endif

endmodule

// File: rtl/prefix_sequencer.sv
// Super FX prefix sequencer: decodes TO/FROM/WITH/ALT prefixes, drives the
// prefix-register strobes and mux selects. ALT support under SEQ_ALT_PREFIX_EN.
module prefix_sequencer
  import sfx_seq_pkg::*;
#(
  parameter int EXEC_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  prefix_sequencer_if.slave  bus,
  output logic [3:0]         instr,
  output logic               to,
  output logic               from,
  output logic               resflags,
  output logic [1:0]         ssel,
  output logic [1:0]         dsel,
  output logic               b_flag,
  output logic [1:0]         alt,
  output logic               is_move,
  output logic               is_moves
);

  localparam int CNT_W  = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
  localparam int TO_LIM = (EXEC_TIMEOUT > 0) ? EXEC_TIMEOUT - 1 : 0;

  seq_state_t state, state_nxt;
  logic [7:0] opreg;
  logic [CNT_W-1:0] exec_cnt;
  logic exec_start_q;

  logic accept;
  logic to_nxt, from_nxt, start_nxt, clr_nxt;
  logic b_nxt, move_nxt, moves_nxt;
  logic [1:0] ssel_nxt, dsel_nxt;
  logic timeout_hit;

  logic is_to, is_from, is_with, is_alt;
  logic [1:0] alt_code;

  prefix_opcode_classifier u_classifier (
    .opcode   (opreg),
    .is_to    (is_to),
    .is_from  (is_from),
    .is_with  (is_with),
    .is_alt   (is_alt),
    .alt_code (alt_code)
  );

  // Counter holds EXEC cycles already spent; it is zero on the entry cycle.
  assign timeout_hit = (EXEC_TIMEOUT > 0) && (exec_cnt == CNT_W'(TO_LIM));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    to_nxt    = 1'b0;
    from_nxt  = 1'b0;
    start_nxt = 1'b0;
    clr_nxt   = 1'b0;
    b_nxt     = b_flag;
    move_nxt  = is_move;
    moves_nxt = is_moves;
    ssel_nxt  = ssel;
    dsel_nxt  = dsel;
    case (state)
      ST_IDLE: begin
        if (bus.op_valid) begin
          accept    = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_nxt = ST_IDLE;
        if (is_to && !b_flag) begin
          to_nxt = 1'b1;
        end else if (is_to) begin
          move_nxt  = 1'b1;
          ssel_nxt  = SEL_PREFIX;
          dsel_nxt  = SEL_INSTR;
          start_nxt = 1'b1;
          state_nxt = ST_EXEC;
        end else if (is_from && !b_flag) begin
          from_nxt = 1'b1;
        end else if (is_from) begin
          moves_nxt = 1'b1;
          ssel_nxt  = SEL_INSTR;
          dsel_nxt  = SEL_PREFIX;
          start_nxt = 1'b1;
          state_nxt = ST_EXEC;
        end else if (is_with) begin
          to_nxt   = 1'b1;
          from_nxt = 1'b1;
          b_nxt    = 1'b1;
        end else if (!is_alt) begin
          ssel_nxt  = SEL_PREFIX;
          dsel_nxt  = SEL_PREFIX;
          start_nxt = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done || timeout_hit) begin
          clr_nxt   = 1'b1;
          b_nxt     = 1'b0;
          move_nxt  = 1'b0;
          moves_nxt = 1'b0;
          ssel_nxt  = SEL_PREFIX;
          dsel_nxt  = SEL_PREFIX;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      opreg        <= 8'h00;
      to           <= 1'b0;
      from         <= 1'b0;
      resflags     <= 1'b1;
      exec_start_q <= 1'b0;
      b_flag       <= 1'b0;
      is_move      <= 1'b0;
      is_moves     <= 1'b0;
      ssel         <= SEL_PREFIX;
      dsel         <= SEL_PREFIX;
      exec_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      to           <= to_nxt;
      from         <= from_nxt;
      resflags     <= clr_nxt;
      exec_start_q <= start_nxt;
      b_flag       <= b_nxt;
      is_move      <= move_nxt;
      is_moves     <= moves_nxt;
      ssel         <= ssel_nxt;
      dsel         <= dsel_nxt;
      exec_cnt     <= (state == ST_EXEC) ? exec_cnt + 1'b1 : '0;
      if (accept) begin
        opreg <= bus.opcode;
      end
    end
  end

`ifdef SEQ_ALT_PREFIX_EN
  logic [1:0] alt_q, alt_nxt;

  always_comb begin
    alt_nxt = alt_q;
    if (state == ST_DECODE && is_alt) begin
      alt_nxt = alt_code;
    end else if (clr_nxt) begin
      alt_nxt = ALT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alt_q <= ALT_NONE;
    end else begin
      alt_q <= alt_nxt;
    end
  end

  assign alt = alt_q;
`else
  logic unused_alt;
  assign unused_alt = ^alt_code;
  assign alt = ALT_NONE;
`endif

  assign instr          = opreg[3:0];
  assign bus.op_ready   = (state == ST_IDLE);
  assign bus.exec_start = exec_start_q;

endmodule
